// File: rtl/ws2812_color_sched_if.sv
// ws2812_color_sched_if
//   Bundles the colour-detection levels, the datapath handshake and the frame
//   configuration outputs of the WS2812 frame scheduler.
//
//   master : the scheduler. It receives r/g/b_valid and frame_done and drives
//            ws2812_start, cfg_data, cfg_num, color_code and timeout_err.
//   slave  : the surrounding logic (detector plus serialising datapath).
interface ws2812_color_sched_if;
    logic        r_valid;
    logic        g_valid;
    logic        b_valid;
    logic        frame_done;
    logic        ws2812_start;
    logic [23:0] cfg_data;
    logic [5:0]  cfg_num;
    logic [1:0]  color_code;
    logic        timeout_err;

    modport master (
        input  r_valid, g_valid, b_valid, frame_done,
        output ws2812_start, cfg_data, cfg_num, color_code, timeout_err
    );

    modport slave (
        output r_valid, g_valid, b_valid, frame_done,
        input  ws2812_start, cfg_data, cfg_num, color_code, timeout_err
    );
endinterface

// File: rtl/ws2812_color_sched.sv
// ws2812_color_sched
//   Filters the r/g/b detection levels into a stable colour, converts it to a
//   GRB word and schedules WS2812 frames. A frame is requested on an accepted
//   colour change or on a periodic refresh. A latch gap follows every frame.
//   A watchdog ends the wait if the datapath never reports completion.
//
//   sys_clk       system clock
//   sys_rst_n     asynchronous active-low reset
//   bus.r_valid   red detected (level)
//   bus.g_valid   green detected (level)
//   bus.b_valid   blue detected (level)
//   bus.frame_done   one-cycle completion pulse from the datapath
//   bus.ws2812_start one-cycle frame request
//   bus.cfg_data     GRB word for every LED of the frame
//   bus.cfg_num      LED_NUM-1
//   bus.color_code   accepted colour: 0 off, 1 red, 2 green, 3 blue
//   bus.timeout_err  sticky watchdog flag
module ws2812_color_sched #(
    parameter int          STABLE_CYC  = 16,
    parameter int          REFRESH_CYC = 2_500_000,
    parameter int          GAP_CYC     = 15_000,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter int          LED_NUM     = 64,
    parameter logic [7:0]  BRIGHT      = 8'h20
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    ws2812_color_sched_if.master  bus
);

    localparam int STAB_W  = $clog2(STABLE_CYC + 1);
    localparam int REF_W   = $clog2(REFRESH_CYC + 1);
    localparam int TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    function automatic logic [1:0] classify(input logic r, input logic g, input logic b);
        logic [1:0] c;
        case ({r, g, b})
            3'b100:  c = 2'd1;
            3'b010:  c = 2'd2;
            3'b001:  c = 2'd3;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

    function automatic logic [23:0] grb_word(input logic [1:0] c);
        logic [23:0] w;
        case (c)
            2'd1:    w = {8'h00, BRIGHT, 8'h00};
            2'd2:    w = {BRIGHT, 16'h0000};
            2'd3:    w = {16'h0000, BRIGHT};
            default: w = 24'h000000;
        endcase
        return w;
    endfunction

    function automatic logic [STAB_W-1:0] sat_inc(input logic [STAB_W-1:0] v);
        return (v == STAB_LAST) ? v : v + 1'b1;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [1:0]        color_q, color_d;
    logic              pend_q, pend_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic              refr_q, refr_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [23:0]       cfg_q, cfg_d;
    logic              tout_q, tout_d;
    logic [1:0]        cls;
    logic              go;
    logic              commit;
    logic              wrap;
    logic              start;
    logic              wd_expire;

    assign cls       = classify(bus.r_valid, bus.g_valid, bus.b_valid);
    assign go        = (state_q == S_IDLE) && (pend_q || refr_q);
    assign commit    = (stab_q == STAB_LAST) && (cand_q != color_q);
    // A frame_done in the expiry cycle counts as a normal completion.
    assign wd_expire = (state_q == S_WAIT) && !bus.frame_done && (tmr_q == TO_LAST);

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (bus.frame_done || (tmr_q == TO_LAST)) state_d = S_GAP;
            S_GAP:   if (tmr_q == GAP_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        start = 1'b0;
        if (state_q == S_START) start = 1'b1;
    end

    always_comb begin
        cand_d = cand_q;
        stab_d = sat_inc(stab_q);
        if (cls != cand_q) begin
            cand_d = cls;
            stab_d = '0;
        end
        color_d = commit ? cand_q : color_q;

        // A commit on the same edge as the launch must survive: cfg_data is
        // latched from the old colour, so the new one needs its own frame.
        pend_d = commit ? 1'b1 : (go ? 1'b0 : pend_q);

        wrap  = 1'b0;
        ref_d = ref_q + 1'b1;
        if (start) begin
            ref_d = '0;
        end else if (ref_q == REF_LAST) begin
            ref_d = '0;
            wrap  = 1'b1;
        end
        // The frame being launched already covers a coincident wrap.
        refr_d = go ? 1'b0 : (wrap ? 1'b1 : refr_q);

        // One timer serves both the watchdog and the latch gap; it restarts
        // on every state change.
        tmr_d = '0;
        if ((state_d == state_q) && ((state_q == S_WAIT) || (state_q == S_GAP)))
            tmr_d = tmr_q + 1'b1;

        cfg_d  = go ? grb_word(color_q) : cfg_q;
        tout_d = tout_q | wd_expire;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cand_q  <= '0;
            stab_q  <= '0;
            color_q <= '0;
            pend_q  <= 1'b0;
            ref_q   <= '0;
            refr_q  <= 1'b0;
            tmr_q   <= '0;
            cfg_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            color_q <= color_d;
            pend_q  <= pend_d;
            ref_q   <= ref_d;
            refr_q  <= refr_d;
            tmr_q   <= tmr_d;
            cfg_q   <= cfg_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.ws2812_start = start;
    assign bus.cfg_data     = cfg_q;
    assign bus.cfg_num      = 6'(LED_NUM - 1);
    assign bus.color_code   = color_q;
    assign bus.timeout_err  = tout_q;

endmodule

// File: tb/tb_ws2812_color_sched.sv
module tb_ws2812_color_sched;
    localparam int          STABLE_CYC  = 4;
    localparam int          REFRESH_CYC = 200;
    localparam int          GAP_CYC     = 8;
    localparam int          TIMEOUT_CYC = 50;
    localparam int          LED_NUM     = 64;
    localparam logic [7:0]  BRIGHT      = 8'h20;

    localparam logic [23:0] W_OFF = 24'h000000;
    localparam logic [23:0] W_RED = 24'h002000;
    localparam logic [23:0] W_GRN = 24'h200000;
    localparam logic [23:0] W_BLU = 24'h000020;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ws2812_color_sched_if bus();

    ws2812_color_sched #(
        .STABLE_CYC (STABLE_CYC),
        .REFRESH_CYC(REFRESH_CYC),
        .GAP_CYC    (GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .LED_NUM    (LED_NUM),
        .BRIGHT     (BRIGHT)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_starts = 0;
    int          t_last_start = 0;
    int          t_done = 0;
    bit          dp_mute = 1'b0;
    logic [23:0] exp_q[$];
    logic [23:0] cur_word = W_OFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag, input int budget, output int t);
        int n0;
        int k;
        n0 = n_starts;
        k  = 0;
        while ((n_starts == n0) && (k < budget)) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_seen"}, (n_starts != n0), 1);
        t = t_last_start;
    endtask

    // Output monitor: every start pops the next queued frame word, or else
    // must carry the current colour (refresh frame).
    initial begin : mon
        logic        prev_start;
        logic [23:0] prev_cfg;
        logic [23:0] want;
        prev_start = 1'b0;
        prev_cfg   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 1'b0;
                prev_cfg   = bus.cfg_data;
            end else begin
                if (bus.cfg_data !== prev_cfg) chk("cfg_hold", bus.ws2812_start, 1);
                if (bus.ws2812_start) begin
                    chk("start_pulse", prev_start, 0);
                    if (exp_q.size() > 0) want = exp_q.pop_front();
                    else                  want = cur_word;
                    chk("sb_cfg", bus.cfg_data, want);
                    chk("cfg_num", bus.cfg_num, LED_NUM - 1);
                    n_starts++;
                    t_last_start = cyc;
                end
                if (bus.frame_done) t_done = cyc;
                prev_start = bus.ws2812_start;
                prev_cfg   = bus.cfg_data;
            end
        end
    end

    // Datapath model: completion pulse 20 cycles after each start.
    initial begin : dp
        bus.frame_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ws2812_start && !dp_mute) begin
                repeat (20) @(posedge clk);
                #1 bus.frame_done = 1'b1;
                @(posedge clk);
                #1 bus.frame_done = 1'b0;
            end
        end
    end

    initial begin : main
        int rel, t, t2, t3, t4a, t4b, t5, e, p, c, k, n0;
        bus.r_valid = 1'b0;
        bus.g_valid = 1'b0;
        bus.b_valid = 1'b0;

        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_start", bus.ws2812_start, 0);
        chk("rst_cfg", bus.cfg_data, 0);
        chk("rst_color", bus.color_code, 0);
        chk("rst_tout", bus.timeout_err, 0);
        chk("rst_num", bus.cfg_num, LED_NUM - 1);

        // 1: idle refresh frames
        @(posedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        wait_start("s1_first", REFRESH_CYC + 60, t);
        chk("s1_lat", (t - rel >= REFRESH_CYC - 1) && (t - rel <= REFRESH_CYC + 3), 1);
        wait_start("s1_rep", REFRESH_CYC + 60, t2);
        chk("s1_period", (t2 - t >= REFRESH_CYC) && (t2 - t <= REFRESH_CYC + 3), 1);

        // 2: steady red; the edge that first samples the level is cycle N
        step(40);
        exp_q.push_back(W_RED);
        cur_word = W_RED;
        bus.r_valid = 1'b1;
        p = cyc;
        k = 0;
        while ((bus.color_code != 2'd1) && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        c = cyc;
        chk("s2_color", bus.color_code, 1);
        chk("s2_filt_lat", c - p - 1, STABLE_CYC);
        wait_start("s2_start", 10, t);
        chk("s2_trig_lat", t - c, 1);

        // 3: short green pulse is filtered out, refresh timer was restarted
        step(35);
        n0 = n_starts;
        bus.g_valid = 1'b1;
        step(3);
        bus.g_valid = 1'b0;
        step(6);
        chk("s3_color", bus.color_code, 1);
        chk("s3_nostart", n_starts, n0);
        wait_start("s3_refresh", REFRESH_CYC + 60, t3);
        chk("s3_restart", (t3 - t >= REFRESH_CYC) && (t3 - t <= REFRESH_CYC + 3), 1);
        step(35);
        exp_q.push_back(W_OFF);
        cur_word = W_OFF;
        bus.g_valid = 1'b1;
        wait_start("s3_off", 20, t);
        chk("s3_off_color", bus.color_code, 0);

        // 4: red -> blue while waiting for frame_done
        step(35);
        exp_q.push_back(W_RED);
        cur_word = W_RED;
        bus.g_valid = 1'b0;
        wait_start("s4_red", 20, t4a);
        step(3);
        exp_q.push_back(W_BLU);
        cur_word = W_BLU;
        bus.r_valid = 1'b0;
        bus.b_valid = 1'b1;
        n0 = n_starts;
        wait_start("s4_blue", 60, t4b);
        chk("s4_done_seen", (t_done > t4a), 1);
        chk("s4_spacing", t4b - t_done, GAP_CYC + 2);
        chk("s4_color", bus.color_code, 3);
        step(60);
        chk("s4_single", n_starts, n0 + 1);
        chk("s4_sb_empty", exp_q.size(), 0);
        chk("s4_no_tout", bus.timeout_err, 0);

        // 5: datapath silent -> watchdog
        dp_mute = 1'b1;
        exp_q.push_back(W_GRN);
        cur_word = W_GRN;
        bus.b_valid = 1'b0;
        bus.g_valid = 1'b1;
        wait_start("s5_green", 20, t5);
        k = 0;
        while (!bus.timeout_err && (k < TIMEOUT_CYC + 30)) begin
            @(negedge clk);
            k++;
        end
        e = cyc;
        chk("s5_tout", bus.timeout_err, 1);
        chk("s5_tout_lat", (e - t5 >= TIMEOUT_CYC - 1) && (e - t5 <= TIMEOUT_CYC + 2), 1);
        @(posedge clk);
        #1;
        exp_q.push_back(W_RED);
        cur_word = W_RED;
        bus.g_valid = 1'b0;
        bus.r_valid = 1'b1;
        dp_mute = 1'b0;
        wait_start("s5_resume", 30, t);
        chk("s5_gap", (t - e >= GAP_CYC) && (t - e <= GAP_CYC + 3), 1);
        step(40);
        chk("s5_sticky", bus.timeout_err, 1);

        // 6: reset during WAIT
        exp_q.push_back(W_BLU);
        cur_word = W_BLU;
        bus.r_valid = 1'b0;
        bus.b_valid = 1'b1;
        wait_start("s6_blue", 20, t);
        step(5);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_start", bus.ws2812_start, 0);
        chk("s6_rst_cfg", bus.cfg_data, 0);
        chk("s6_rst_color", bus.color_code, 0);
        chk("s6_rst_tout", bus.timeout_err, 0);
        exp_q.delete();
        cur_word = W_OFF;
        bus.b_valid = 1'b0;
        step(4);
        chk("s6_rst_hold", bus.ws2812_start, 0);
        rst_n = 1'b1;
        rel = cyc;
        wait_start("s6_first", REFRESH_CYC + 60, t);
        chk("s6_lat", (t - rel >= REFRESH_CYC - 1) && (t - rel <= REFRESH_CYC + 3), 1);
        wait_start("s6_rep", REFRESH_CYC + 60, t2);
        chk("s6_period", (t2 - t >= REFRESH_CYC) && (t2 - t <= REFRESH_CYC + 3), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ws2812_color_sched.md
# ws2812_color_sched

Frame scheduler between the colour-recognition outputs and the WS2812 serialising datapath. It filters the r/g/b detection levels into a stable colour and converts that colour to a 24-bit GRB word. It issues single-cycle frame-start requests to the datapath on a colour change or on a periodic refresh, and enforces the WS2812 latch gap between frames. A watchdog recovers the scheduler if the datapath never reports completion.

## Interface
Parameters:
- STABLE_CYC, 16: consecutive cycles a candidate colour must persist before it is accepted (≥2).
- REFRESH_CYC, 2_500_000: cycles between forced refresh frames (50 ms at 50 MHz).
- GAP_CYC, 15_000: post-frame latch gap in cycles (300 µs at 50 MHz).
- TIMEOUT_CYC, 1_000_000: maximum wait for frame_done.
- LED_NUM, 64: LEDs per frame (1..64).
- BRIGHT, 8'h20: channel intensity for the active colour.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- r_valid  in  1  red detected (level).
- g_valid  in  1  green detected (level).
- b_valid  in  1  blue detected (level).
- frame_done  in  1  one-cycle pulse from the datapath when the last bit of a frame has been sent.
- ws2812_start  out  1  one-cycle frame request to the datapath.
- cfg_data  out  24  GRB word for every LED of the frame.
- cfg_num  out  6  LED_NUM-1.
- color_code  out  2  accepted colour: 0 off, 1 red, 2 green, 3 blue.
- timeout_err  out  1  sticky flag; set on watchdog expiry.

## Operation
- Classifier (combinational): exactly one valid high gives that colour; none or more than one gives off (0).
- Stability filter:
  - Registered candidate plus counter.
  - Classifier ≠ candidate: load candidate and clear the counter.
  - Otherwise the counter increments, saturating at STABLE_CYC-1.
  - Counter == STABLE_CYC-1 and candidate ≠ color_code: color_code ← candidate, and the pending flag is set.
- Refresh timer:
  - Free-running, 0..REFRESH_CYC-1.
  - Wrap sets the refresh flag.
  - Restarts from 0 whenever ws2812_start is asserted.
- FSM states: IDLE, START, WAIT, GAP.
  - IDLE → START when pending or refresh is set. In START: latch cfg_data from color_code, assert ws2812_start, clear pending and refresh.
  - START → WAIT unconditionally after 1 cycle.
  - WAIT → GAP on frame_done.
  - WAIT → GAP when the watchdog reaches TIMEOUT_CYC-1. This sets timeout_err.
  - GAP → IDLE after GAP_CYC cycles.
- cfg_data encoding (GRB):
  - off: 24'h000000
  - red: {8'h00, BRIGHT, 8'h00}
  - green: {BRIGHT, 16'h0000}
  - blue: {16'h0000, BRIGHT}
- cfg_data changes only in START and is stable throughout WAIT and GAP.
- Colour changes during START, WAIT or GAP only set pending. They are served on the first IDLE cycle after GAP.
- Multiple changes while busy are coalesced into one frame carrying the latest color_code.
- Pending and refresh set together produce one frame.
- frame_done outside WAIT is ignored.
- timeout_err clears only on reset.

## Timing
- Reset values:
  - ws2812_start 0, cfg_data 0, color_code 0, timeout_err 0.
  - FSM IDLE; pending, refresh, all counters and candidate 0.
- cfg_num is the constant LED_NUM-1 and is valid at all times.
- Filter latency: a classifier change first seen at cycle N updates color_code at N+STABLE_CYC. pending is set on the same edge.
- Trigger latency: pending or refresh high in IDLE at cycle M gives START, ws2812_start=1 and the new cfg_data at M+1. ws2812_start is low at M+2.
- Frame spacing: the earliest next ws2812_start is GAP_CYC+2 cycles after the frame_done cycle.
- Reset asserted mid-frame: all state returns to reset values immediately, with no start glitch. After release, the first frame is issued once the first refresh or colour event occurs.

## Test plan
Bench parameters: STABLE_CYC=4, REFRESH_CYC=200, GAP_CYC=8, TIMEOUT_CYC=50, LED_NUM=64, BRIGHT=8'h20. The datapath model pulses frame_done 20 cycles after start.

1. Reset release, no valids:
   - First ws2812_start at the refresh wrap with cfg_data=0, cfg_num=63.
   - Repeats every 200 cycles while idle.
2. r_valid high steadily:
   - color_code=1 four cycles after the edge.
   - ws2812_start one cycle later with cfg_data=24'h002000.
   - Refresh timer restarted.
3. g_valid pulsed for 3 cycles, then removed:
   - No colour change and no extra frame.
   - r_valid and g_valid high together classify as off.
4. Change red → blue during WAIT:
   - No start before frame_done + GAP.
   - Then exactly one start with cfg_data=24'h000020.
5. frame_done never pulsed:
   - timeout_err=1 fifty cycles after the start.
   - GAP of 8 cycles, then normal scheduling resumes.
6. sys_rst_n low during WAIT:
   - All outputs 0 immediately.
   - After release, behaviour matches scenario 1.
